mdr_sequencer: RTL and testbench

- Control FSM for the MDR multiply/divide/square-root datapath.
- Accepts one operation request at a time and sequences the operand register bank by driving its enable, ready and shift_enable inputs, plus the operand-source select.
- Iterates the required number of cycles per operation, then flags the result as valid.
- Sits between the host interface and the operand/ALU datapath.

---
 rtl/mdr_pkg.sv | 34 +++
 rtl/mdr_iter_counter.sv | 35 +++
 rtl/mdr_sequencer.sv | 136 +++++++++++++
 tb/tb_mdr_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// MDR sequencer shared types.
// Operation codes, state encoding, iteration counts.
package mdr_pkg;

  localparam int DW_MDR = 8;

  typedef enum logic [1:0] {
    MULT = 2'b01,
    DIV  = 2'b10,
    SQRT = 2'b11
  } op_bus;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    ERROR
  } seq_state_t;

  // RUN cycles needed by each operation.
  function automatic int iter_count(
    op_bus op,
    int    dw = DW_MDR
  );
    case (op)
      MULT:    return dw;
      DIV:     return 2 * dw;
      SQRT:    return dw;
      default: return dw;
    endcase
  endfunction

endpackage

// File: rtl/mdr_iter_counter.sv
// MDR iteration counter.
// Saturating count, terminal compare, phase bit.
module mdr_iter_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] n,
  output logic [CW-1:0] cnt,
  output logic          phase,
  output logic          tc
);

  // Count RUN cycles, stop at n, flip phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (inc) begin
      if (cnt != n) cnt <= cnt + CW'(1);
      phase <= ~phase;
    end
  end

  // Last RUN cycle when count hits n-1.
  always_comb begin
    tc = (cnt == n - CW'(1));
  end

endmodule

// File: rtl/mdr_sequencer.sv
// MDR datapath control sequencer.
// Moore FSM driving operand bank and shifts.
module mdr_sequencer
  import mdr_pkg::*;
#(
  parameter  int DW = DW_MDR,
  localparam int CW = $clog2(2*DW+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  op_bus         op_sel_in,
  input  logic [DW-1:0] divisor_in,
  input  logic          abort,
  output op_bus         op_sel,
  output logic          load,
  output logic          enable,
  output logic          ready,
  output logic          shift_enable,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] iter_cnt
);

  seq_state_t    state;
  seq_state_t    state_nx;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          cnt_tc;
  logic          phase;
  logic          op_ok;
  logic          div_zero;
  logic [CW-1:0] n;

  assign op_ok    = op_sel_in inside {MULT, DIV, SQRT};
  assign div_zero = (op_sel_in == DIV) &&
                    (divisor_in == '0);
  assign n        = CW'(iter_count(op_sel, DW));

  mdr_iter_counter #(
    .CW(CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .n     (n),
    .cnt   (iter_cnt),
    .phase (phase),
    .tc    (cnt_tc)
  );

  // State register; op latched only on IDLE start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_sel <= op_bus'('0);
    end else begin
      state <= state_nx;
      if (state == IDLE && start)
        op_sel <= op_sel_in;
    end
  end

  // Next state and counter control.
  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!op_ok || div_zero)
            state_nx = ERROR;
          else
            state_nx = LOAD;
        end
      end
      LOAD: begin
        cnt_clr  = 1'b1;
        state_nx = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          cnt_clr  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_inc = 1'b1;
          if (cnt_tc) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      ERROR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore output decode from registered state.
  always_comb begin
    load         = 1'b0;
    enable       = 1'b0;
    ready        = 1'b0;
    shift_enable = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      LOAD: begin
        load   = 1'b1;
        enable = 1'b1;
      end
      RUN: begin
        enable       = 1'b1;
        shift_enable = (op_sel != MULT) && !phase;
      end
      DONE: begin
        done   = 1'b1;
        enable = 1'b1;
      end
      ERROR: begin
        err   = 1'b1;
        ready = 1'b1;
      end
      default: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mdr_sequencer.sv
// MDR sequencer testbench.
// Directed vectors plus multi-cycle sequences.
module tb_mdr_sequencer;
  import mdr_pkg::*;

  localparam int DW = 8;
  localparam int CW = $clog2(2*DW+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  op_bus         op_sel_in;
  op_bus         op_sel;
  logic [DW-1:0] divisor_in;
  logic          load;
  logic          enable;
  logic          ready;
  logic          shift_enable;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] iter_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  dv;
    int          done_c;
    int          err_c;
    int          n_load;
    int          n_en;
    int          n_busy;
    logic [31:0] shv;
    int          run_max;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  mdr_sequencer #(
    .DW(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_sel_in    (op_sel_in),
    .divisor_in   (divisor_in),
    .abort        (abort),
    .op_sel       (op_sel),
    .load         (load),
    .enable       (enable),
    .ready        (ready),
    .shift_enable (shift_enable),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .iter_cnt     (iter_cnt)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int done_c;
    int err_c;
    int n_ld;
    int n_en;
    int n_bz;
    int n_dn;
    int rmax;
    int bad_op;
    int idle_after;
    logic [31:0] shv;
    done_c = -1;
    err_c = -1;
    n_ld = 0;
    n_en = 0;
    n_bz = 0;
    n_dn = 0;
    rmax = 0;
    bad_op = 0;
    idle_after = 0;
    shv = '0;
    @(negedge clk);
    start = 1'b1;
    op_sel_in = op_bus'(v.op);
    divisor_in = v.dv;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0;
        op_sel_in = op_bus'(~v.op);
      end
      if (load) n_ld++;
      if (enable) n_en++;
      if (busy) n_bz++;
      if (shift_enable) shv[c] = 1'b1;
      if (done) begin
        n_dn++;
        if (done_c < 0) done_c = c;
      end
      if (err && err_c < 0) err_c = c;
      if (enable && !load && !done &&
          int'(iter_cnt) > rmax)
        rmax = int'(iter_cnt);
      if (busy && op_sel != op_bus'(v.op))
        bad_op++;
      if ((v.done_c > 0 && c == v.done_c + 1) ||
          (v.err_c > 0 && c == v.err_c + 1))
        idle_after = (ready && !busy) ? 1 : 0;
    end
    chk($sformatf("v%0d done_cyc", i), done_c, v.done_c);
    chk($sformatf("v%0d err_cyc", i), err_c, v.err_c);
    chk($sformatf("v%0d n_done", i), n_dn,
        (v.done_c > 0) ? 1 : 0);
    chk($sformatf("v%0d n_load", i), n_ld, v.n_load);
    chk($sformatf("v%0d n_enable", i), n_en, v.n_en);
    chk($sformatf("v%0d n_busy", i), n_bz, v.n_busy);
    chk($sformatf("v%0d shift_mask", i), shv, v.shv);
    chk($sformatf("v%0d run_max_cnt", i), rmax,
        v.run_max);
    chk($sformatf("v%0d op_sel_hold", i), bad_op, 0);
    chk($sformatf("v%0d idle_after", i), idle_after, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int first;
    int second;
    int nd;

    vecs[0] = '{2'b01, 8'd5,   10, -1, 1, 10, 10,
                32'h0,     7};
    vecs[1] = '{2'b10, 8'd3,   18, -1, 1, 18, 18,
                32'h15554, 15};
    vecs[2] = '{2'b11, 8'd0,   10, -1, 1, 10, 10,
                32'h154,   7};
    vecs[3] = '{2'b10, 8'd0,   -1,  1, 0,  0,  1,
                32'h0,     0};
    vecs[4] = '{2'b00, 8'd7,   -1,  1, 0,  0,  1,
                32'h0,     0};
    vecs[5] = '{2'b10, 8'h80,  18, -1, 1, 18, 18,
                32'h15554, 15};
    vecs[6] = '{2'b01, 8'd0,   10, -1, 1, 10, 10,
                32'h0,     7};

    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    op_sel_in = MULT;
    divisor_in = 8'd1;
    #1;
    chk("reset_ctl",
        {load, enable, ready, shift_enable,
         busy, done, err}, 7'b0010000);
    chk("reset_cnt", iter_cnt, 0);
    chk("reset_op", op_sel, 0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_ctl",
        {load, enable, ready, shift_enable,
         busy, done, err}, 7'b0010000);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // error then immediate restart at cycle 2
    @(negedge clk);
    start = 1'b1;
    op_sel_in = DIV;
    divisor_in = 8'd0;
    tick();
    chk("er_err", err, 1);
    op_sel_in = MULT;
    divisor_in = 8'd3;
    tick();
    chk("er_idle2", busy, 0);
    tick();
    chk("er_load3", load, 1);
    start = 1'b0;
    found = -1;
    for (int c = 4; c <= 30; c++) begin
      tick();
      if (done && found < 0) found = c;
    end
    chk("er_done_cyc", found, 12);

    // SQRT with restarts in RUN and DONE
    @(negedge clk);
    start = 1'b1;
    op_sel_in = SQRT;
    divisor_in = 8'd0;
    first = -1;
    second = -1;
    nd = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (done) begin
        nd++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (c == 11) chk("sq_idle11", busy, 0);
      start = (c == 5 || c == 10 || c == 11);
    end
    chk("sq_first_done", first, 10);
    chk("sq_second_done", second, 21);
    chk("sq_n_done", nd, 2);

    // abort in RUN
    @(negedge clk);
    start = 1'b1;
    op_sel_in = MULT;
    divisor_in = 8'd1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    chk("ab_cnt5", iter_cnt, 3);
    abort = 1'b1;
    tick();
    chk("ab_busy", busy, 0);
    chk("ab_ready", ready, 1);
    chk("ab_cnt", iter_cnt, 0);
    abort = 1'b0;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || err) nd++;
    end
    chk("ab_no_done", nd, 0);

    // abort with start in IDLE: start wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    op_sel_in = DIV;
    divisor_in = 8'd2;
    tick();
    chk("abst_load", load, 1);
    start = 1'b0;
    abort = 1'b0;
    found = -1;
    for (int c = 2; c <= 24; c++) begin
      tick();
      if (done && found < 0) found = c;
    end
    chk("abst_done_cyc", found, 18);

    // reset mid-RUN
    @(negedge clk);
    start = 1'b1;
    op_sel_in = MULT;
    divisor_in = 8'd1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    chk("rs_cnt5", iter_cnt, 3);
    rst = 1'b0;
    #1;
    chk("rs_async_ctl",
        {load, enable, ready, shift_enable,
         busy, done, err}, 7'b0010000);
    chk("rs_async_cnt", iter_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || err || busy) nd++;
    end
    chk("rs_quiet", nd, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
